// File: rtl/rr_arbiter_8_pkg.sv
// rr_arbiter_8_pkg: shared constants and FSM state encoding for the round-robin arbiter
package rr_arbiter_8_pkg;
  localparam int N_REQ = 8;
  localparam int IDX_W = 3;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
endpackage

// File: rtl/rr_arbiter_8_if.sv
// rr_arbiter_8_if: request/grant bundle between clients and the arbiter
interface rr_arbiter_8_if;
  import rr_arbiter_8_pkg::*;
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic gnt_valid;
  logic timeout;
  modport master (output req, input gnt, gnt_idx, gnt_valid, timeout);
  modport slave (input req, output gnt, gnt_idx, gnt_valid, timeout);
endinterface

// File: rtl/rr_arbiter_8_p_encoder_8.sv
// p_encoder_8: 8:3 priority encoder, highest set index wins
module p_encoder_8
  import rr_arbiter_8_pkg::*;
(
  input  logic [N_REQ-1:0] in,
  output logic [IDX_W-1:0] out,
  output logic             valid
);
  // scan upward so the highest set bit overwrites lower ones
  always_comb begin
    out = '0;
    for (int i = 0; i < N_REQ; i++) out = in[i] ? IDX_W'(i) : out;
  end
  assign valid = |in;
endmodule

// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: 8-way round-robin arbiter with grant hold and optional hold timeout
module rr_arbiter_8
  import rr_arbiter_8_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input logic clk,
  input logic rst,
  rr_arbiter_8_if.slave bus
);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             timeout_q, timeout_d;
  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0] rot;
  logic [IDX_W-1:0] enc_out, winner;
  logic             enc_valid, owner_req, expired;
  // rotate so the slot at ptr lands on bit 7, then map the encoded index back
  always_comb begin
    dbl    = {bus.req, bus.req} << (~ptr_q);
    rot    = dbl[2*N_REQ-1:N_REQ];
    winner = enc_out + ptr_q + 3'd1;
  end
  p_encoder_8 u_enc (.in(rot), .out(enc_out), .valid(enc_valid));
  assign owner_req = bus.req[idx_q];
  assign expired   = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_MAX);
  // grant in IDLE, release on owner drop or hold expiry, otherwise keep counting
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    idx_d      = idx_q;
    gnt_d      = gnt_q;
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;
    if (state_q == IDLE) begin
      if (enc_valid) begin
        state_d    = BUSY;
        gnt_d      = N_REQ'(1) << winner;
        idx_d      = winner;
        hold_cnt_d = CNT_W'(1);
      end
    end else if (!owner_req || expired) begin
      state_d    = IDLE;
      ptr_d      = idx_q - 3'd1;
      idx_d      = '0;
      gnt_d      = '0;
      hold_cnt_d = '0;
      timeout_d  = owner_req;
    end else begin
      hold_cnt_d = (hold_cnt_q == '1) ? hold_cnt_q : hold_cnt_q + 1'b1;
    end
  end
  // state registers with synchronous reset; ptr restarts at 7
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= 3'd7;
      idx_q      <= '0;
      gnt_q      <= '0;
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      idx_q      <= idx_d;
      gnt_q      <= gnt_d;
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end
  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = idx_q;
  assign bus.gnt_valid = state_q;
  assign bus.timeout   = timeout_q;
endmodule

// File: tb/tb_rr_arbiter_8.sv
// tb_rr_arbiter_8: directed and random checks of rr_arbiter_8 against a scan-order reference model
module tb_rr_arbiter_8;
  localparam int MH = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  int m_owner = -1;
  int m_ptr = 7;
  int m_hold = 0;
  logic m_to = 1'b0;
  int n_to;
  rr_arbiter_8_if bus();
  rr_arbiter_8 #(.MAX_HOLD(MH), .CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model(input logic [7:0] r, input logic rs);
    bit found;
    if (rs) begin
      m_owner = -1; m_ptr = 7; m_hold = 0; m_to = 1'b0;
    end else if (m_owner < 0) begin
      m_to = 1'b0;
      found = 1'b0;
      for (int d = 0; d < 8; d++) begin
        int c;
        c = (m_ptr - d + 8) % 8;
        if (!found && r[c]) begin
          found = 1'b1; m_owner = c; m_hold = 1;
        end
      end
    end else if (!r[m_owner]) begin
      m_ptr = (m_owner + 7) % 8; m_owner = -1; m_to = 1'b0;
    end else if (MH != 0 && m_hold == MH) begin
      m_ptr = (m_owner + 7) % 8; m_owner = -1; m_to = 1'b1;
    end else begin
      m_hold++; m_to = 1'b0;
    end
  endtask
  task automatic step(input logic [7:0] r, input logic rs);
    logic [7:0] eg;
    bus.req = r;
    rst = rs;
    @(posedge clk);
    model(r, rs);
    @(negedge clk);
    eg = (m_owner < 0) ? 8'h00 : 8'(1) << m_owner;
    chk("gnt", 32'(bus.gnt), 32'(eg));
    chk("gnt_valid", 32'(bus.gnt_valid), 32'(m_owner >= 0));
    if (m_owner >= 0) chk("gnt_idx", 32'(bus.gnt_idx), 32'(m_owner));
    chk("timeout", 32'(bus.timeout), 32'(m_to));
  endtask
  initial begin
    bus.req = 8'h00;
    @(negedge clk);
    step(8'hFF, 1'b1);
    step(8'hFF, 1'b1);
    chk("rst_gnt", 32'(bus.gnt), 32'h0);
    step(8'hFF, 1'b0);
    chk("first_gnt", 32'(bus.gnt), 32'h80);
    chk("first_idx", 32'(bus.gnt_idx), 32'd7);
    for (int k = 0; k < 9; k++) begin
      int o;
      o = (7 - k + 8) % 8;
      chk("fair_order", 32'(bus.gnt_idx), 32'(o));
      step(8'hFF, 1'b0);
      step(8'hFF, 1'b0);
      step(8'hFF & ~(8'(1) << o), 1'b0);
      chk("fair_idle", 32'(bus.gnt_valid), 32'd0);
      step(8'hFF, 1'b0);
    end
    step(8'h00, 1'b1);
    step(8'h08, 1'b0);
    chk("wrap_c3", 32'(bus.gnt), 32'h08);
    step(8'h00, 1'b0);
    step(8'h82, 1'b0);
    chk("wrap_c1", 32'(bus.gnt_idx), 32'd1);
    step(8'h80, 1'b0);
    step(8'h80, 1'b0);
    chk("wrap_c7", 32'(bus.gnt_idx), 32'd7);
    step(8'h00, 1'b1);
    n_to = 0;
    for (int i = 0; i < 15; i++) begin
      step(8'h01, 1'b0);
      n_to += int'(bus.timeout);
    end
    chk("timeout_count", 32'(n_to), 32'd3);
    step(8'h00, 1'b1);
    step(8'h04, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(8'h84, 1'b0);
      chk("no_preempt", 32'(bus.gnt), 32'h04);
    end
    step(8'h80, 1'b0);
    chk("preempt_idle", 32'(bus.gnt), 32'h00);
    step(8'h80, 1'b0);
    chk("preempt_next", 32'(bus.gnt), 32'h80);
    step(8'h00, 1'b1);
    step(8'h20, 1'b0);
    chk("mid_c5", 32'(bus.gnt), 32'h20);
    step(8'h20, 1'b1);
    chk("mid_rst", 32'(bus.gnt), 32'h00);
    step(8'h20, 1'b0);
    chk("mid_regrant", 32'(bus.gnt), 32'h20);
    for (int i = 0; i < 500; i++) begin
      logic [7:0] r;
      r = 8'($urandom) | 8'($urandom);
      if ($urandom_range(0, 3) == 0) r = 8'($urandom) & 8'($urandom);
      step(r, $urandom_range(0, 63) == 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
